// File: rtl/decode_queue_stage.sv
// decode_queue_stage: fetch queue feeding a registered MIPS decoder with load-use bubbles, flush and stall counter
module decode_queue_stage #(
  parameter int DEPTH = 4,
  parameter int PC_WIDTH = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       w_flush,
  input  logic                       w_in_valid,
  output logic                       w_in_ready,
  input  logic [PC_WIDTH-1:0]        w_pc_in,
  input  logic [31:0]                w_instr_in_32,
  output logic                       w_out_valid,
  input  logic                       w_out_ready,
  output logic [PC_WIDTH-1:0]        w_pc_out,
  output logic [31:0]                w_instr_out_32,
  output logic [5:0]                 w_op_type_6,
  output logic [4:0]                 w_rs_addr_5,
  output logic [4:0]                 w_rt_addr_5,
  output logic [4:0]                 w_rd_addr_5,
  output logic [4:0]                 w_sh_amt_5,
  output logic [5:0]                 w_func_6,
  output logic [15:0]                w_alu_imm_val_16,
  output logic [25:0]                w_branch_imm_val_26,
  output logic                       w_alu_op,
  output logic                       w_unsigned_op,
  output logic                       w_imm_op,
  output logic                       w_byte_op,
  output logic                       w_shift_op,
  output logic                       w_mem_op,
  output logic                       w_write_op,
  output logic                       w_branch_op,
  output logic                       w_jump_op,
  output logic                       w_nop,
  output logic                       w_illegal,
  output logic [STALL_CNT_WIDTH-1:0] w_stall_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [10:0] ALU = 11'h400, UNS = 11'h200, IMM = 11'h100, BYT = 11'h080;
  localparam logic [10:0] SHF = 11'h040, MEM = 11'h020, WR = 11'h010, BR = 11'h008;
  localparam logic [10:0] JMP = 11'h004, NOP = 11'h002, ILL = 11'h001;
  logic [PC_WIDTH+31:0]       r_mem [DEPTH];
  logic [AW:0]                r_wp, r_rp;
  logic                       r_valid;
  logic [PC_WIDTH-1:0]        r_pc;
  logic [31:0]                r_instr;
  logic [5:0]                 r_op;
  logic [10:0]                r_fl;
  logic [STALL_CNT_WIDTH-1:0] r_cnt;
  logic [PC_WIDTH+31:0]       w_head;
  logic [31:0]                w_hi;
  logic                       w_empty, w_free, w_ld_op, w_hazard, w_load, w_push;
  logic [5:0]                 w_dop;
  logic [10:0]                w_dfl;
  assign w_head = r_mem[r_rp[AW-1:0]];
  assign w_hi = w_head[31:0];
  assign w_empty = r_wp == r_rp;
  assign w_in_ready = (r_wp - r_rp) != (AW+1)'(DEPTH);
  assign w_free = !r_valid | w_out_ready;
  assign w_ld_op = r_instr[31:26] inside {6'h23, 6'h20, 6'h24};
  // the departing load's rt is only a hazard if the next instruction reads it
  assign w_hazard = r_valid & w_out_ready & !w_empty & w_ld_op & (r_instr[20:16] != 5'd0) &
                    ((w_hi[25:21] == r_instr[20:16]) | (w_hi[20:16] == r_instr[20:16]));
  assign w_load = w_free & !w_empty & !w_hazard;
  assign w_push = w_in_valid & w_in_ready;
  always_comb begin
    w_dop = w_hi[31:26];
    w_dfl = '0;
    case (w_hi[31:26])
      6'h00: begin
        w_dop = w_hi[5:0];
        case (w_hi[5:0])
          6'h08, 6'h09: w_dfl = JMP;
          6'h21, 6'h23, 6'h19, 6'h1B, 6'h2B: w_dfl = ALU | UNS;
          6'h20, 6'h22, 6'h18, 6'h1A, 6'h2A: w_dfl = ALU;
          6'h02, 6'h03: w_dfl = ALU | IMM | SHF;
          6'h00: w_dfl = (w_hi[10:6] != 5'd0) ? (ALU | IMM | SHF) : NOP;
          6'h04, 6'h06, 6'h07: w_dfl = ALU | SHF;
          default: w_dfl = NOP | ILL;
        endcase
      end
      6'h01: begin
        w_dop = (w_hi[20:17] == 4'd0) ? {1'b0, w_hi[20:16]} : 6'd0;
        w_dfl = (w_hi[20:17] == 4'd0) ? BR : (NOP | ILL);
      end
      6'h09, 6'h0B: w_dfl = ALU | IMM | UNS;
      6'h0A, 6'h0D, 6'h0E: w_dfl = ALU | IMM;
      6'h23: w_dfl = MEM;
      6'h2B: w_dfl = MEM | WR;
      6'h0F: w_dfl = MEM | IMM;
      6'h20: w_dfl = MEM | BYT;
      6'h24: w_dfl = MEM | BYT | UNS;
      6'h28: w_dfl = MEM | WR | BYT;
      6'h02, 6'h03: w_dfl = JMP | IMM;
      6'h04, 6'h05, 6'h06, 6'h07: w_dfl = BR;
      default: begin
        w_dop = 6'd0;
        w_dfl = NOP | ILL;
      end
    endcase
  end
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {w_pc_in, w_instr_in_32};
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_valid <= 1'b0;
      r_pc <= '0;
      r_instr <= '0;
      r_op <= '0;
      r_fl <= '0;
      r_cnt <= '0;
    end else if (w_flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_valid <= 1'b0;
      r_fl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_load) begin
        r_rp <= r_rp + (AW+1)'(1);
        r_valid <= 1'b1;
        r_pc <= w_head[PC_WIDTH+31:32];
        r_instr <= w_hi;
        r_op <= w_dop;
        r_fl <= w_dfl;
      end else if (w_free) r_valid <= 1'b0;
      if (w_hazard && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign w_out_valid = r_valid;
  assign w_pc_out = r_pc;
  assign w_instr_out_32 = r_instr;
  assign w_op_type_6 = r_op;
  assign w_rs_addr_5 = r_instr[25:21];
  assign w_rt_addr_5 = r_instr[20:16];
  assign w_rd_addr_5 = r_instr[15:11];
  assign w_sh_amt_5 = r_instr[10:6];
  assign w_func_6 = r_instr[5:0];
  assign w_alu_imm_val_16 = r_instr[15:0];
  assign w_branch_imm_val_26 = r_instr[25:0];
  assign {w_alu_op, w_unsigned_op, w_imm_op, w_byte_op, w_shift_op, w_mem_op,
          w_write_op, w_branch_op, w_jump_op, w_nop, w_illegal} = r_fl;
  assign w_stall_count = r_cnt;
endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Registered, buffered successor to the combinational decoder.
- Accepts fetched {pc, instruction} pairs into a DEPTH-entry queue, decodes the queue head, and holds the decoded fields in an output register with a valid/ready handshake.
- Adds load-use hazard bubbles, pipeline flush, an illegal-instruction flag and a saturating stall counter.
- Sits between fetch and the register-read/execute stage.

Parameters:
- DEPTH, 4: queue entries; power of two, >= 2.
- PC_WIDTH, 32: width of the pc carried alongside each instruction.
- STALL_CNT_WIDTH, 16: width of the saturating hazard-stall counter.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- w_flush  in  1  discard queue contents and output register.
- w_in_valid  in  1  fetch offers an instruction.
- w_in_ready  out  1  queue can accept; equals !full.
- w_pc_in  in  PC_WIDTH  pc of offered instruction.
- w_instr_in_32  in  32  offered instruction word.
- w_out_valid  out  1  output register holds a decoded instruction.
- w_out_ready  in  1  downstream consumes the output register this cycle.
- w_pc_out  out  PC_WIDTH  pc of decoded instruction.
- w_instr_out_32  out  32  raw instruction word.
- w_op_type_6, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5, w_func_6, w_alu_imm_val_16, w_branch_imm_val_26  out  6/5/5/5/5/6/16/26  decoded fields; bit slices as in the existing decoder.
- w_alu_op, w_unsigned_op, w_imm_op, w_byte_op, w_shift_op, w_mem_op, w_write_op, w_branch_op, w_jump_op, w_nop, w_illegal  out  1 each  class flags.
- w_stall_count  out  STALL_CNT_WIDTH  number of hazard bubbles inserted; saturates at all-ones.

Behaviour:
- Reset: queue empty; every output register zero, so w_out_valid=0, all flags 0, w_stall_count=0. w_in_ready=1 from the first cycle after reset. Reset mid-operation drops all contents.
- Push: push when w_in_valid & w_in_ready.
  - w_in_ready is combinational from the full flag only; no push-while-full bypass, even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
- Load/pop: the output register loads when (!w_out_valid | w_out_ready) & queue non-empty & !hazard. A load pops the queue head.
  - If (!w_out_valid | w_out_ready) and the queue is empty, w_out_valid goes to 0.
  - If (!w_out_valid | w_out_ready) and hazard is true, w_out_valid goes to 0 (bubble), the head is not popped, and w_stall_count increments (saturating).
  - Otherwise the output register holds its value.
- Latency: an instruction pushed into an empty queue at edge N is visible at the output after edge N+1.
- Simultaneous push and pop while neither full nor empty: both occur; count unchanged.
- Hazard: true when all of the following hold:
  - w_out_valid & w_out_ready;
  - the output holds LW (0x23), LB (0x20) or LBU (0x24);
  - output rt != 0;
  - the queue head's rs or rt field equals output rt.
  - At most one bubble per load, because the bubble clears w_out_valid.
- Flush: w_flush=1 at an edge does the following.
  - Empties the queue and clears w_out_valid and all flags.
  - Ignores any push in the same cycle.
  - Blocks any output load in the same cycle.
  - w_stall_count is kept.
  - Flush has priority over everything except reset.
- Decode: applied to the queue head when it is loaded; flags not listed for a class are 0.
- SPECIAL (op 0x00): w_op_type_6 = funct.
  - JR 0x08, JALR 0x09: jump.
  - ADDU 0x21, SUBU 0x23, MULTU 0x19, DIVU 0x1B, SLTU 0x2B: alu, unsigned.
  - ADD 0x20, SUB 0x22, MULT 0x18, DIV 0x1A, SLT 0x2A: alu.
  - SRL 0x02, SRA 0x03, and SLL 0x00 with shamt>0: alu, imm, shift.
  - SLLV 0x04, SRLV 0x06, SRAV 0x07: alu, shift.
  - SLL with shamt=0: nop.
  - Any other funct: nop, illegal.
- ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ORI 0x0D, XORI 0x0E: alu, imm; unsigned for ADDIU and SLTIU.
- LW 0x23, SW 0x2B, LUI 0x0F, LB 0x20, LBU 0x24, SB 0x28: mem.
  - write for SW, SB.
  - byte for LB, LBU, SB.
  - unsigned for LBU.
  - imm for LUI.
- J 0x02, JAL 0x03: jump, imm. BEQ 0x04, BNE 0x05, BLEZ 0x06, BGTZ 0x07: branch.
- REGIMM (op 0x01):
  - rt=0 (BLTZ) or rt=1 (BGEZ): branch, w_op_type_6={1'b0, rt}.
  - Otherwise: nop, illegal, w_op_type_6=0.
- Other opcodes: nop, illegal, w_op_type_6=0. No X values are ever driven.
- For non-SPECIAL, non-REGIMM instructions, w_op_type_6 = opcode.

Test Plan:
- Reset, push 0x00A41020 (ADD $2,$5,$4) with w_out_ready=1 -> valid after 2 edges; alu=1, rd=2, op_type=0x20, illegal=0.
- Hold w_out_ready=0, push 5 instructions, DEPTH=4 -> first goes to the output register, 4 are queued, w_in_ready=0; release -> drained in push order, pc order preserved.
- LW $8,0($9) (0x8D280000) followed by ADDU $10,$8,$8 -> one bubble cycle (w_out_valid=0), w_stall_count=1, then ADDU with unsigned=1; repeat with rt=0 -> no bubble.
- Queue holding 3 entries plus a valid output, assert w_flush together with w_in_valid -> next cycle w_out_valid=0, queue empty, pushed word lost, w_stall_count unchanged.
- Decode 0x00000000 -> nop=1, illegal=0. Decode 0x04020000 (REGIMM rt=2) -> nop=1, illegal=1, op_type=0. Decode 0xFC000000 -> illegal=1.
- STALL_CNT_WIDTH=2, force 5 hazards -> w_stall_count stops at 3.
